// File: rtl/wb_regfile_scoreboard_pkg.sv
// Shared sizing and types for the write-back register file and its busy scoreboard.
package wb_regfile_scoreboard_pkg;

    localparam int XLEN     = 32;
    localparam int NREG     = 32;
    localparam int REG_AW   = $clog2(NREG);
    localparam int REG_ZERO = 0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   word_t;

endpackage

// File: rtl/wb_regfile_scoreboard_reg_busy_scoreboard.sv
// Per-register busy bits: set at issue, cleared at write-back, and the RAW/WAW stall request.
module reg_busy_scoreboard
    import wb_regfile_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_write,
    input  reg_addr_t        wb_rd,
    input  reg_addr_t        rs1_addr,
    input  reg_addr_t        rs2_addr,
    input  logic             iss_valid,
    input  reg_addr_t        iss_rd,
    input  logic             iss_rs1_used,
    input  logic             iss_rs2_used,
    output logic             stall,
    output logic [NREG-1:0]  busy_mask
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            raw1;
    logic            raw2;
    logic            waw;
    logic            wb_en;

    assign wb_en = wb_write && (wb_rd != reg_addr_t'(REG_ZERO));

    // A write-back landing this cycle releases its consumer immediately, because
    // the bypass delivers the value in the same cycle.
    always_comb begin
        raw1  = iss_rs1_used && busy_q[rs1_addr] && !(wb_write && (wb_rd == rs1_addr));
        raw2  = iss_rs2_used && busy_q[rs2_addr] && !(wb_write && (wb_rd == rs2_addr));
        waw   = (iss_rd != reg_addr_t'(REG_ZERO)) && busy_q[iss_rd]
                && !(wb_write && (wb_rd == iss_rd));
        stall = iss_valid && (raw1 || raw2 || waw);
    end

    // Clear first, then set: a new producer issued this cycle keeps the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (iss_valid && !stall && (iss_rd != reg_addr_t'(REG_ZERO))) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_mask = busy_q;

endmodule

// File: rtl/wb_regfile_scoreboard.sv
// Architectural register file with write-through bypass on two read ports, plus the issue scoreboard.
module wb_regfile_scoreboard
    import wb_regfile_scoreboard_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_write,
    input  reg_addr_t        wb_rd,
    input  word_t            wb_data,
    input  reg_addr_t        rs1_addr,
    input  reg_addr_t        rs2_addr,
    output word_t            rs1_data,
    output word_t            rs2_data,
    // Issue handshake: iss_valid offers an instruction, !stall accepts it this cycle;
    // a stalled instruction is held unchanged and re-presented by decode.
    input  logic             iss_valid,
    input  reg_addr_t        iss_rd,
    input  logic             iss_rs1_used,
    input  logic             iss_rs2_used,
    output logic             stall,
    output logic [NREG-1:0]  busy_mask
);

    word_t regs_q [NREG];
    logic  wb_en;

    assign wb_en = wb_write && (wb_rd != reg_addr_t'(REG_ZERO));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en) begin
            regs_q[wb_rd] <= wb_data;
        end
    end

    always_comb begin
        rs1_data = regs_q[rs1_addr];
        if (wb_en && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
        end
        if (rs1_addr == reg_addr_t'(REG_ZERO)) begin
            rs1_data = '0;
        end
    end

    always_comb begin
        rs2_data = regs_q[rs2_addr];
        if (wb_en && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
        end
        if (rs2_addr == reg_addr_t'(REG_ZERO)) begin
            rs2_data = '0;
        end
    end

    reg_busy_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .wb_write     (wb_write),
        .wb_rd        (wb_rd),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .iss_rs1_used (iss_rs1_used),
        .iss_rs2_used (iss_rs2_used),
        .stall        (stall),
        .busy_mask    (busy_mask)
    );

endmodule

// File: tb/tb_wb_regfile_scoreboard.sv
// Directed and random stimulus for wb_regfile_scoreboard against an array-based reference model.
module tb_wb_regfile_scoreboard;

    logic        clk;
    logic        rst;
    logic        wb_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        iss_rs1_used;
    logic        iss_rs2_used;
    logic        stall;
    logic [31:0] busy_mask;

    int checks;
    int passed;

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;

    wb_regfile_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .wb_write     (wb_write),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs1_data     (rs1_data),
        .rs2_data     (rs2_data),
        .iss_valid    (iss_valid),
        .iss_rd       (iss_rd),
        .iss_rs1_used (iss_rs1_used),
        .iss_rs2_used (iss_rs2_used),
        .stall        (stall),
        .busy_mask    (busy_mask)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model
    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_busy = 32'h0;
    endtask

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 32'h0;
        if (wb_write && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_stall();
        logic landing1, landing2, landing_d, hz;
        landing1  = wb_write && (wb_rd == rs1_addr);
        landing2  = wb_write && (wb_rd == rs2_addr);
        landing_d = wb_write && (wb_rd == iss_rd);
        hz = (iss_rs1_used && m_busy[rs1_addr] && !landing1) ||
             (iss_rs2_used && m_busy[rs2_addr] && !landing2) ||
             (iss_rd != 5'd0 && m_busy[iss_rd] && !landing_d);
        return iss_valid && hz;
    endfunction

    // Driver
    task automatic drive(input logic w, input logic [4:0] wrd, input logic [31:0] wd,
                         input logic [4:0] a1, input logic [4:0] a2,
                         input logic iv, input logic [4:0] ird, input logic u1, input logic u2);
        wb_write = w;  wb_rd = wrd;  wb_data = wd;
        rs1_addr = a1; rs2_addr = a2;
        iss_valid = iv; iss_rd = ird; iss_rs1_used = u1; iss_rs2_used = u2;
    endtask

    // One cycle from a negedge: check combinational outputs, clock, update model, check busy.
    task automatic cycle(input string tag);
        logic st_e;
        #1;
        st_e = exp_stall();
        check({tag, ".rs1"}, rs1_data, exp_read(rs1_addr));
        check({tag, ".rs2"}, rs2_data, exp_read(rs2_addr));
        check({tag, ".stall"}, {31'h0, stall}, {31'h0, st_e});
        @(posedge clk);
        if (wb_write && wb_rd != 5'd0) begin
            m_regs[wb_rd] = wb_data;
            m_busy[wb_rd] = 1'b0;
        end
        if (iss_valid && !st_e && iss_rd != 5'd0) m_busy[iss_rd] = 1'b1;
        @(negedge clk);
        check({tag, ".busy"}, busy_mask, m_busy);
    endtask

    initial begin
        checks = 0;
        passed = 0;
        model_reset();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 1'b0, 5'd0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        // 1. reset state
        #1;
        check("rst.rs1", rs1_data, 32'h0);
        check("rst.rs2", rs2_data, 32'h0);
        check("rst.busy", busy_mask, 32'h0);
        check("rst.stall", {31'h0, stall}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 2. write then read
        drive(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 1'b0);
        cycle("wr5");
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        #1 check("rd5.explicit", rs1_data, 32'hDEADBEEF);
        cycle("rd5");

        // 3. same-cycle bypass on both ports
        drive(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        check("byp.rs1", rs1_data, 32'h12345678);
        check("byp.rs2", rs2_data, 32'h12345678);
        cycle("byp");

        // 4. x0 protection
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
        #1 check("x0.same", rs1_data, 32'h0);
        cycle("x0w");
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        check("x0.busy0", {31'h0, busy_mask[0]}, 32'h0);
        cycle("x0r");

        // 5. RAW stall and release
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd3, 1'b0, 1'b0);
        cycle("raw.iss");
        check("raw.busy8", busy_mask, 32'h8);
        drive(1'b0, 5'd0, 32'h0, 5'd3, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        #1 check("raw.stall", {31'h0, stall}, 32'h1);
        cycle("raw.hold");
        drive(1'b1, 5'd3, 32'hA5A5_0003, 5'd3, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0);
        #1 check("raw.release", {31'h0, stall}, 32'h0);
        cycle("raw.wb");
        check("raw.busy3", {31'h0, busy_mask[3]}, 32'h0);

        // 6. set beats clear, WAW, async reset mid-stall
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0);
        cycle("waw.pre");
        drive(1'b1, 5'd4, 32'h0000_0444, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0);
        #1 check("waw.unblock", {31'h0, stall}, 32'h0);
        cycle("waw.setwin");
        check("waw.busy4", {31'h0, busy_mask[4]}, 32'h1);
        drive(1'b0, 5'd0, 32'h0, 5'd4, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0);
        #1 check("waw.stall", {31'h0, stall}, 32'h1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rstmid.busy", busy_mask, 32'h0);
        check("rstmid.stall", {31'h0, stall}, 32'h0);
        check("rstmid.rs1", rs1_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Random traffic on a narrow register window so hazards collide often
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
